enemy_hit_array: RTL

ENEMY_HIT_ARRAY -- requirements
Module: enemy_hit_array

---
 rtl/enemy_hit_array.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/enemy_hit_array.sv
// Per-slot enemy health/explosion FSMs with bullet hitbox overlap detection.
// Only the lowest-index overlapping ALIVE slot takes a hit; a bullet scores once until re-armed.
module enemy_hit_array #(
   parameter int N_ENEMY  = 4,
   parameter int HP_W     = 3,
   parameter int BOX_XL   = 10,
   parameter int BOX_XR   = 50,
   parameter int BOX_YU   = 40,
   parameter int BOX_YD   = 50,
   parameter int Y_OFF    = 480,
   parameter int BOOM_CYC = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [10*N_ENEMY-1:0]     ep_x,
   input  logic [10*N_ENEMY-1:0]     ep_y,
   input  logic [N_ENEMY-1:0]        spawn,
   input  logic [HP_W-1:0]           spawn_hp,
   input  logic [9:0]                b_x,
   input  logic [9:0]                b_y,
   input  logic                      bullet_en,
   output logic                      bullet_hit,
   output logic [2:0]                hit_id,
   output logic [HP_W*N_ENEMY-1:0]   health,
   output logic [N_ENEMY-1:0]        alive,
   output logic [N_ENEMY-1:0]        boom
);

   typedef enum logic [1:0] {IDLE, ALIVE, BOOM} slot_state_t;

   localparam int CW = (BOOM_CYC > 1) ? $clog2(BOOM_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BOOM_CYC - 1);
   localparam logic signed [11:0] XL   = 12'(BOX_XL);
   localparam logic signed [11:0] XR   = 12'(BOX_XR);
   localparam logic signed [11:0] YU   = 12'(BOX_YU);
   localparam logic signed [11:0] YD   = 12'(BOX_YD);
   localparam logic signed [11:0] YOFF = 12'(Y_OFF);

   slot_state_t       state     [N_ENEMY];
   slot_state_t       state_nxt [N_ENEMY];
   logic [HP_W-1:0]   hp_q      [N_ENEMY];
   logic [HP_W-1:0]   hp_nxt    [N_ENEMY];
   logic [CW-1:0]     cnt_q     [N_ENEMY];
   logic [CW-1:0]     cnt_nxt   [N_ENEMY];
   logic signed [11:0] ex       [N_ENEMY];
   logic signed [11:0] ey       [N_ENEMY];
   logic signed [11:0] bx, by;
   logic [N_ENEMY-1:0] overlap;
   logic               armed;
   logic               hit_any;
   logic [2:0]         hit_idx;

   // 12-bit signed compare so hitbox edges near 0 cannot wrap
   always_comb begin
      bx = $signed({2'b00, b_x});
      by = $signed({2'b00, b_y});
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
         ex[i] = $signed({2'b00, ep_x[10*i +: 10]});
         ey[i] = $signed({2'b00, ep_y[10*i +: 10]}) + YOFF;
         overlap[i] = (bx >= ex[i] - XL) && (bx < ex[i] + XR) &&
                      (by > ey[i] - YU) && (by < ey[i] + YD);
      end
   end

   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
         if (!hit_any && bullet_en && armed && state[i] == ALIVE &&
             overlap[i] && hp_q[i] != '0) begin
            hit_any = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
         state_nxt[i] = state[i];
         hp_nxt[i]    = hp_q[i];
         cnt_nxt[i]   = cnt_q[i];
         case (state[i])
            IDLE: begin
               if (spawn[i] && spawn_hp != '0) begin
                  state_nxt[i] = ALIVE;
                  hp_nxt[i]    = spawn_hp;
               end
            end
            ALIVE: begin
               if (hit_any && hit_idx == 3'(i)) begin
                  hp_nxt[i] = hp_q[i] - HP_W'(1);
                  if (hp_q[i] == HP_W'(1)) begin
                     state_nxt[i] = BOOM;
                     cnt_nxt[i]   = '0;
                  end
               end
            end
            BOOM: begin
               if (cnt_q[i] == CNT_LAST) begin
                  state_nxt[i] = IDLE;
                  cnt_nxt[i]   = '0;
               end else begin
                  cnt_nxt[i] = cnt_q[i] + CW'(1);
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N_ENEMY; i++) begin
            state[i] <= IDLE;
            hp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         armed      <= 1'b1;
         bullet_hit <= 1'b0;
         hit_id     <= '0;
      end else begin
         for (int unsigned i = 0; i < N_ENEMY; i++) begin
            state[i] <= state_nxt[i];
            hp_q[i]  <= hp_nxt[i];
            cnt_q[i] <= cnt_nxt[i];
         end
         if (!bullet_en)
            armed <= 1'b1;
         else if (hit_any)
            armed <= 1'b0;
         bullet_hit <= hit_any;
         if (hit_any)
            hit_id <= hit_idx;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
         health[HP_W*i +: HP_W] = hp_q[i];
         alive[i]               = (state[i] == ALIVE);
         boom[i]                = (state[i] == BOOM);
      end
   end

endmodule
